// File: rtl/uart_dev_pkg.sv
// rtl/uart_dev_pkg.sv - register map, bit positions and FSM encoding for uart_tx_dev
package uart_dev_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int ST_EMPTY_BIT = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_IRQ_BIT   = 4;

   localparam int CTRL_TXEN_BIT = 0;
   localparam int CTRL_IE_BIT   = 1;
   localparam int CTRL_PEN_BIT  = 2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      START  = S_START,
      DATA   = S_DATA,
      PARITY = S_PARITY,
      STOP   = S_STOP
   } tx_state_t;

   // Divisors below 2 would make a zero-length bit; clamp them.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd2 : d;
   endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// rtl/uart_tx_dev_if.sv - device bus (Addr/WE/Din/Dout) between CPU bridge and uart_tx_dev
interface uart_tx_dev_if;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - TX byte FIFO, power-of-two depth, wrapping pointers
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - bus-attached 8N1 UART transmitter with TX FIFO and drain IRQ
// Optional even parity bit when UART_TX_DEV_PARITY_EN is defined.
module uart_tx_dev
   import uart_dev_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_dev_if.slave  bus,
   output logic          IRQ,
   output logic          txd
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          txen;
   logic          ie;
   logic          pen;
   logic          ovf;
   logic          irq_q;
   logic [15:0]   div;

   tx_state_t     state;
   logic [15:0]   baud_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;
   logic          par;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;

   logic          busy;
   logic          bit_end;
   logic          data_wr;
   logic [15:0]   load_val;
   logic          unused_bits;

   assign busy      = (state != IDLE);
   assign bit_end   = (baud_cnt == 16'd0);
   assign load_val  = eff_div(div) - 16'd1;
   assign data_wr   = bus.WE && (bus.Addr[3:2] == REG_DATA);
   // A new frame may start from IDLE, or directly at the end of a stop bit.
   assign fifo_pop  = txen && !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));
   assign fifo_push = data_wr && (!fifo_full || fifo_pop);
   assign IRQ       = irq_q;
   assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:16], fifo_count};

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (bus.Din[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         txen  <= 1'b0;
         ie    <= 1'b0;
         div   <= DIV_RESET;
         ovf   <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (bus.WE) begin
            case (bus.Addr[3:2])
               REG_STATUS: ovf <= 1'b0;
               REG_CTRL: begin
                  txen <= bus.Din[CTRL_TXEN_BIT];
                  ie   <= bus.Din[CTRL_IE_BIT];
               end
               REG_DIV:  div <= bus.Din[15:0];
               default:  ;
            endcase
         end
         if (data_wr && fifo_full && !fifo_pop)
            ovf <= 1'b1;
         irq_q <= ie && fifo_empty && !busy;
      end
   end

`ifdef UART_TX_DEV_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pen <= 1'b0;
      else if (bus.WE && (bus.Addr[3:2] == REG_CTRL))
         pen <= bus.Din[CTRL_PEN_BIT];
   end
`else
   assign pen = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         txd      <= 1'b1;
         baud_cnt <= 16'd0;
         shift    <= 8'd0;
         bit_idx  <= 3'd0;
         par      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (fifo_pop) begin
                  shift    <= fifo_dout;
                  par      <= ^fifo_dout;
                  baud_cnt <= load_val;
                  txd      <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  txd      <= shift[0];
                  shift    <= shift >> 1;
                  bit_idx  <= 3'd0;
                  baud_cnt <= load_val;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= load_val;
                  if (bit_idx == 3'd7) begin
                     if (pen) begin
                        txd   <= par;
                        state <= PARITY;
                     end else begin
                        txd   <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  txd      <= 1'b1;
                  baud_cnt <= load_val;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (fifo_pop) begin
                     shift    <= fifo_dout;
                     par      <= ^fifo_dout;
                     baud_cnt <= load_val;
                     txd      <= 1'b0;
                     state    <= START;
                  end else begin
                     txd   <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.Dout = 32'd0;
      case (bus.Addr[3:2])
         REG_STATUS: bus.Dout[4:0]  = {irq_q, ovf, busy, fifo_full, fifo_empty};
         REG_CTRL:   bus.Dout[2:0]  = {pen, ie, txen};
         REG_DIV:    bus.Dout[15:0] = div;
         default:    bus.Dout       = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - scoreboard bench for uart_tx_dev: serial frames, FIFO flags, IRQ, DIV, reset
`timescale 1ns/1ps
module tb_uart_tx_dev;
   localparam int DEPTH = 8;
   localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic IRQ;
   logic txd;

   uart_tx_dev_if bus ();

   uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus),
      .IRQ   (IRQ),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] sb_q[$];
   bit mon_en = 1'b0;
   int cur_div = 4;
   bit pen_on = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // Line level during bit slot j of a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int j, input bit p);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (p && j == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
      @(negedge clk);
      bus.Addr = {28'd0, r, 2'b00};
      bus.WE   = 1'b1;
      bus.Din  = d;
      @(posedge clk);
      @(negedge clk);
      bus.WE   = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
      bus.Addr = {28'd0, r, 2'b00};
      #1 d = bus.Dout;
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] st;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         bus_read(A_STATUS, st);
         if (!st[2] && st[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_in_time", {31'd0, ok}, 32'd1);
   endtask

   // Monitor: every falling start edge is checked against the oldest expected byte.
   always begin
      logic [7:0] exp_b;
      int nb;
      int d;
      int errs;
      bit p;
      @(negedge clk);
      if (mon_en && rst_n && txd === 1'b0) begin
         d = cur_div;
         p = pen_on;
         nb = p ? 11 : 10;
         errs = 0;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: unexpected frame, got start bit expected idle line");
         end else begin
            exp_b = sb_q.pop_front();
            for (int i = 1; i < nb * d; i++) begin
               @(negedge clk);
               if (txd !== frame_bit(exp_b, i / d, p)) errs++;
            end
            chk($sformatf("frame_%02h_bit_errors", exp_b), errs, 0);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  b0;
      logic [7:0]  b1;
      int n;
      int d;
      int busy_cnt;
      int errs;

      bus.Addr = 32'd0;
      bus.WE   = 1'b0;
      bus.Din  = 32'd0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_irq", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(A_STATUS, rd); chk("rst_status", rd, 32'h1);
      bus_read(A_DIV, rd);    chk("rst_div", rd, 32'd434);
      bus_read(A_CTRL, rd);   chk("rst_ctrl", rd, 32'd0);
      bus_read(A_DATA, rd);   chk("data_reads_zero", rd, 32'd0);

      // Single 0x55 frame, exact per-clock waveform and busy length
      bus_write(A_DIV, 32'd4);
      bus_write(A_CTRL, 32'd1);
      bus_write(A_DATA, 32'h55);
      bus.Addr = {28'd0, A_STATUS, 2'b00};
      chk("txd_idle_at_write", {31'd0, txd}, 32'd1);
      busy_cnt = 0;
      errs = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (txd !== frame_bit(8'h55, (c - 1) / 4, 1'b0)) errs++;
         if (bus.Dout[2]) busy_cnt++;
      end
      chk("frame55_bit_errors", errs, 0);
      chk("frame55_busy_clocks", busy_cnt, 40);
      @(negedge clk);
      chk("frame55_busy_after", {31'd0, bus.Dout[2]}, 32'd0);

      // Fill, overflow, clear ovf, then back-to-back drain
      d = $urandom_range(2, 5);
      bus_write(A_DIV, d);
      cur_div = d;
      bus_write(A_CTRL, 32'd0);
      for (int i = 0; i < 9; i++) begin
         b0 = 8'($urandom_range(0, 255));
         bus_write(A_DATA, {24'd0, b0});
         if (i < 8) sb_q.push_back(b0);
         bus_read(A_STATUS, rd);
         if (i == 7) begin
            chk("full_after_8", {31'd0, rd[1]}, 32'd1);
            chk("ovf_after_8", {31'd0, rd[3]}, 32'd0);
         end
         if (i == 8) chk("ovf_after_9", {31'd0, rd[3]}, 32'd1);
      end
      bus_write(A_STATUS, 32'd0);
      bus_read(A_STATUS, rd);
      chk("ovf_cleared", {31'd0, rd[3]}, 32'd0);
      mon_en = 1'b1;
      bus_write(A_CTRL, 32'd1);
      bus.Addr = {28'd0, A_STATUS, 2'b00};
      n = 0;
      for (int g = 0; g < 4000; g++) begin
         @(negedge clk);
         if (bus.Dout[2]) n++;
         else break;
      end
      chk("b2b_busy_clocks", n, 80 * d);
      chk("b2b_sb_empty", sb_q.size(), 0);

      // Randomized rounds, optionally streaming while the transmitter runs
      for (int r = 0; r < 5; r++) begin
         bus_write(A_CTRL, 32'd0);
         d = $urandom_range(2, 7);
         bus_write(A_DIV, d);
         cur_div = d;
         if ($urandom_range(0, 1) == 1) bus_write(A_CTRL, 32'd1);
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            b0 = 8'($urandom_range(0, 255));
            sb_q.push_back(b0);
            bus_write(A_DATA, {24'd0, b0});
         end
         bus_write(A_CTRL, 32'd1);
         wait_idle(2000);
         chk("rand_sb_empty", sb_q.size(), 0);
      end
      mon_en = 1'b0;

      // IRQ behaviour
      bus_write(A_DIV, 32'd4);
      bus_write(A_CTRL, 32'd3);
      @(negedge clk);
      chk("irq_idle_ie", {31'd0, IRQ}, 32'd1);
      bus_write(A_DATA, 32'hA3);
      chk("irq_at_push_edge", {31'd0, IRQ}, 32'd1);
      for (int k = 1; k <= 43; k++) begin
         @(negedge clk);
         chk($sformatf("irq_frame_n%0d", k), {31'd0, IRQ}, {31'd0, (k >= 42)});
      end
      bus_write(A_DATA, 32'h3C);
      chk("irq_hold_push", {31'd0, IRQ}, 32'd1);
      @(negedge clk);
      chk("irq_drop_push", {31'd0, IRQ}, 32'd0);
      wait_idle(200);
      @(negedge clk);
      chk("irq_back", {31'd0, IRQ}, 32'd1);
      bus_write(A_CTRL, 32'd1);
      chk("irq_hold_ie", {31'd0, IRQ}, 32'd1);
      @(negedge clk);
      chk("irq_drop_ie", {31'd0, IRQ}, 32'd0);

      // DIV change and TXEN clear mid-frame
      bus_write(A_CTRL, 32'd0);
      bus_write(A_DIV, 32'd4);
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      bus_write(A_DATA, {24'd0, b0});
      bus_write(A_DATA, {24'd0, b1});
      bus_write(A_CTRL, 32'd1);
      errs = 0;
      fork
         begin
            for (int k = 1; k <= 76; k++) begin
               @(negedge clk);
               if (k <= 4) begin
                  if (txd !== 1'b0) errs++;
               end else if (txd !== frame_bit(b0, 1 + (k - 5) / 8, 1'b0)) begin
                  errs++;
               end
            end
         end
         begin
            @(negedge clk);
            bus_write(A_DIV, 32'd8);
            repeat (15) @(negedge clk);
            bus_write(A_CTRL, 32'd0);
         end
      join
      chk("div_change_bit_errors", errs, 0);
      repeat (20) @(negedge clk);
      bus_read(A_STATUS, rd);
      chk("held_status", rd & 32'h7, 32'd0);
      chk("held_txd", {31'd0, txd}, 32'd1);
      sb_q.push_back(b1);
      cur_div = 8;
      mon_en = 1'b1;
      bus_write(A_CTRL, 32'd1);
      wait_idle(300);
      chk("held_sb_empty", sb_q.size(), 0);
      mon_en = 1'b0;

      // Parity option
`ifdef UART_TX_DEV_PARITY_EN
      bus_write(A_DIV, 32'd4);
      cur_div = 4;
      pen_on = 1'b1;
      mon_en = 1'b1;
      bus_write(A_CTRL, 32'd5);
      sb_q.push_back(8'h07);
      bus_write(A_DATA, 32'h07);
      wait_idle(200);
      chk("parity_sb_empty", sb_q.size(), 0);
      bus_read(A_CTRL, rd);
      chk("ctrl_pen_rw", rd, 32'd5);
      mon_en = 1'b0;
      pen_on = 1'b0;
      bus_write(A_CTRL, 32'd0);
`else
      bus_write(A_CTRL, 32'd7);
      bus_read(A_CTRL, rd);
      chk("ctrl_pen_ignored", rd, 32'd3);
      bus_write(A_CTRL, 32'd0);
`endif

      // Reset asserted mid-frame
      bus_write(A_DIV, 32'd4);
      bus_write(A_CTRL, 32'd1);
      bus_write(A_DATA, 32'h00);
      bus_write(A_DATA, 32'hF0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_txd", {31'd0, txd}, 32'd1);
      chk("midrst_irq", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(A_STATUS, rd); chk("midrst_status", rd, 32'h1);
      bus_read(A_DIV, rd);    chk("midrst_div", rd, 32'd434);
      bus_read(A_CTRL, rd);   chk("midrst_ctrl", rd, 32'd0);
      bus_write(A_CTRL, 32'd1);
      repeat (5) @(negedge clk);
      bus_read(A_STATUS, rd); chk("midrst_fifo_discarded", rd, 32'h1);
      chk("midrst_txd_idle", {31'd0, txd}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
